seg7_scan_driver: RTL and testbench

//   Consumes the 32-bit seg7_data word from the segment-7 display content mux.

---
 rtl/seg7_scan_driver.sv | 119 +++++++++++
 tb/tb_seg7_scan_driver.sv | 132 +++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 8-digit multiplexed common-anode 7-segment scan driver
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver #(
  parameter int DIV_W     = 17,
  parameter int BLANK_CYC = 64,
  parameter int DIGITS    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] seg7_data,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam logic [DIV_W-1:0] CNT_MAX  = '1;
  localparam logic [DIV_W-1:0] BLANK    = DIV_W'(BLANK_CYC);
  localparam logic [2:0]       IDX_LAST = 3'(DIGITS - 1);
  localparam logic [7:0]       AN_MASK  = 8'((9'h1 << DIGITS) - 9'h1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic             fd_q, fd_d;

  logic             tick;
  logic [3:0]       nib;
  logic             digit_on;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

`ifdef SEG7_LZB_EN
  // Highest digit worth lighting; digit 0 stays lit even when shadow is zero.
  logic [2:0] hi_digit;

  always_comb begin
    hi_digit = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (shadow_q[4*i +: 4] != 4'h0) hi_digit = 3'(i);
    end
  end

  assign digit_on = (idx_q <= hi_digit);
`else
  assign digit_on = 1'b1;
`endif

  assign tick = (cnt_q == CNT_MAX);
  assign nib  = shadow_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    fd_d     = 1'b0;
    an_d     = 8'hFF;
    seg_d    = 8'hFF;

    // Shadow reload shares the slot-wrap edge of the last digit so a frame never tears.
    if (tick) begin
      if (idx_q == IDX_LAST) begin
        idx_d    = 3'd0;
        shadow_d = seg7_data;
        fd_d     = 1'b1;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end

    if ((cnt_q >= BLANK) && digit_on) begin
      an_d  = ~(8'h01 << idx_q) | ~AN_MASK;
      seg_d = {1'b1, ~hex7(nib)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      shadow_q <= 32'h0;
      an_q     <= 8'hFF;
      seg_q    <= 8'hFF;
      fd_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      fd_q     <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
// Expectations follow SEG7_LZB_EN when the macro is defined for the build.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] seg7_data = 32'h0;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  int          n_eval = 0;
  int          n_fail = 0;
  int          k = 0;
  logic [31:0] exp_sh = 32'h0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .DIV_W    (4),
    .BLANK_CYC(2),
    .DIGITS   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seg7_data (seg7_data),
    .an        (an),
    .seg       (seg),
    .frame_done(frame_done)
  );

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] expv);
    n_eval++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic bit lit(input int d, input logic [31:0] sh);
`ifdef SEG7_LZB_EN
    int hi;
    hi = 0;
    for (int i = 1; i < 8; i++) if (sh[4*i +: 4] != 4'h0) hi = i;
    return (d <= hi);
`else
    return 1'b1;
`endif
  endfunction

  // Advance n cycles; check an/seg/frame_done each cycle against the scan model.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] din;
      logic [7:0]  ea;
      logic [7:0]  es;
      logic        efd;
      int          pre, c, d;
      din = seg7_data;
      @(posedge clk);
      #1;
      k++;
      pre = k - 1;
      c   = pre % 16;
      d   = (pre / 16) % 8;
      if (c < 2 || !lit(d, exp_sh)) begin
        ea = 8'hFF;
        es = 8'hFF;
      end else begin
        ea = ~(8'h01 << d);
        es = {1'b1, ~hex7(exp_sh[4*d +: 4])};
      end
      efd = (k % 128 == 0);
      chk("an", k, {24'h0, an}, {24'h0, ea});
      chk("seg", k, {24'h0, seg}, {24'h0, es});
      chk("frame_done", k, {31'h0, frame_done}, {31'h0, efd});
      if (k % 128 == 0) exp_sh = din;
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", 0, {24'h0, an}, 32'h0000_00FF);
    chk("rst_seg", 0, {24'h0, seg}, 32'h0000_00FF);
    chk("rst_fd", 0, {31'h0, frame_done}, 32'h0);

    rst       = 1'b0;
    seg7_data = 32'h1234_5678;
    k         = 0;
    exp_sh    = 32'h0;
    run(128);
    run(52);
    seg7_data = 32'hDEAD_BEEF;
    run(76);
    run(89);

    chk("pre_cnt", k, {28'h0, dut.cnt_q}, 32'd9);
    chk("pre_idx", k, {29'h0, dut.idx_q}, 32'd5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_an", k, {24'h0, an}, 32'h0000_00FF);
    chk("mid_rst_seg", k, {24'h0, seg}, 32'h0000_00FF);
    chk("mid_rst_fd", k, {31'h0, frame_done}, 32'h0);
    chk("mid_rst_cnt", k, {28'h0, dut.cnt_q}, 32'h0);
    chk("mid_rst_idx", k, {29'h0, dut.idx_q}, 32'h0);
    chk("mid_rst_shadow", k, dut.shadow_q, 32'h0);

    rst       = 1'b0;
    seg7_data = 32'h0000_00A0;
    k         = 0;
    exp_sh    = 32'h0;
    run(256);
    seg7_data = 32'h0;
    run(256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
